// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer: state encoding,
// loss counter saturation value and the shared counter width function.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } state_e;

  localparam logic [7:0] LOSS_CNT_MAX = 8'hFF;

  // Width of the single counter that times RESET, WAIT and STABLE.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Single-bit two-flop synchronizer for the asynchronous PLL lock signal.
module sync_2ff (
  input  logic refclk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge refclk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock sequencer: holds the PLL in reset, waits for stable lock,
// then releases the system reset. Optional macro PLL_RESET_SEQ_LOSS_FILTER_EN
// debounces lock loss while running.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES     = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRIES    = 3,
  parameter int LOSS_FILTER    = 4
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam int CW = cnt_width(RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

  if (RST_CYCLES < 1 || STABLE_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
      MAX_RETRIES < 1 || MAX_RETRIES > 15 || LOSS_FILTER < 1) begin : g_bad_params
    $error("pll_reset_sequencer: illegal parameter value");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_d;
  logic [7:0]    loss_d;
  logic          cnt_inc;
  logic          lk;
  logic          loss_event;

  sync_2ff u_lock_sync (
    .refclk (refclk),
    .rst    (rst),
    .d      (pll_locked),
    .q      (lk)
  );

`ifdef PLL_RESET_SEQ_LOSS_FILTER_EN
  localparam int FW = $clog2(LOSS_FILTER + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(LOSS_FILTER - 1);

  logic [FW-1:0] filt_q;

  assign loss_event = !lk && (filt_q == FILT_LAST);

  // Counts consecutive low lock samples in RUN; any high sample restarts it.
  always_ff @(posedge refclk) begin
    if (rst) begin
      filt_q <= '0;
    end else if (state_q == S_RUN && !lk && !loss_event) begin
      filt_q <= filt_q + FW'(1);
    end else begin
      filt_q <= '0;
    end
  end
`else
  assign loss_event = !lk;
`endif

  always_comb begin
    state_d = state_q;
    retry_d = retry_cnt;
    loss_d  = loss_cnt;
    cnt_inc = 1'b1;
    case (state_q)
      S_RESET: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lk) begin
          state_d = S_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_cnt + 4'd1;
          state_d = (retry_d == RETRY_LIMIT) ? S_FAIL : S_RESET;
        end
      end
      S_STABLE: begin
        if (!lk) begin
          state_d = S_WAIT;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RUN;
          retry_d = 4'd0;
        end
      end
      S_RUN: begin
        cnt_inc = 1'b0;
        if (loss_event) begin
          state_d = S_RESET;
          if (loss_cnt != LOSS_CNT_MAX) loss_d = loss_cnt + 8'd1;
        end
      end
      S_FAIL: begin
        cnt_inc = 1'b0;
      end
      default: begin
        state_d = S_RESET;
      end
    endcase
    // A relock request restarts the whole sequence but never counts as a loss.
    if (relock_req) begin
      state_d = S_RESET;
      retry_d = 4'd0;
      loss_d  = loss_cnt;
    end
    if (state_d != state_q || relock_req) cnt_d = '0;
    else                                  cnt_d = cnt_q + CW'(cnt_inc);
  end

  // Outputs are decoded from the next state so they move with the state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      retry_cnt <= 4'd0;
      loss_cnt  <= 8'd0;
      pll_rst   <= 1'b1;
      sys_reset <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_cnt <= retry_d;
      loss_cnt  <= loss_d;
      pll_rst   <= (state_d == S_RESET) || (state_d == S_FAIL);
      sys_reset <= (state_d != S_RUN);
      ready     <= (state_d == S_RUN);
      fail      <= (state_d == S_FAIL);
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: directed scenarios plus random
// lock/relock/reset traffic against a countdown-based behavioural model.
module tb_pll_reset_sequencer;

  localparam int RST_N     = 4;
  localparam int STABLE_N  = 8;
  localparam int TIMEOUT_N = 20;
  localparam int RETRY_N   = 2;
  localparam int FILTER_N  = 3;
`ifdef PLL_RESET_SEQ_LOSS_FILTER_EN
  localparam int DROP_N = FILTER_N;
`else
  localparam int DROP_N = 1;
`endif

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst, sys_reset, ready, fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  int checks = 0;
  int errors = 0;

  always #10 refclk = ~refclk;

  pll_reset_sequencer #(
    .RST_CYCLES     (RST_N),
    .STABLE_CYCLES  (STABLE_N),
    .TIMEOUT_CYCLES (TIMEOUT_N),
    .MAX_RETRIES    (RETRY_N),
    .LOSS_FILTER    (FILTER_N)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .sys_reset  (sys_reset),
    .ready      (ready),
    .fail       (fail),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  // Behavioural model: phases with countdowns, lock seen through a 2-deep delay line.
  typedef enum int {M_HOLD, M_SEEK, M_CONFIRM, M_LIVE, M_DEAD} phase_e;
  phase_e phase = M_HOLD;
  int     left, retries, losses, lowRun;
  bit     modelValid = 1'b0;
  logic   lockPipe[$];

  task automatic modelStep();
    logic lkSeen;
    if (rst) begin
      phase = M_HOLD; left = RST_N; retries = 0; losses = 0; lowRun = 0;
      lockPipe = {1'b0, 1'b0};
      modelValid = 1'b1;
      return;
    end
    if (!modelValid) return;
    lkSeen = lockPipe.pop_front();
    lockPipe.push_back(pll_locked);
    if (relock_req) begin
      phase = M_HOLD; left = RST_N; retries = 0;
      return;
    end
    case (phase)
      M_HOLD: begin
        left--;
        if (left == 0) begin phase = M_SEEK; left = TIMEOUT_N; end
      end
      M_SEEK: begin
        if (lkSeen) begin
          phase = M_CONFIRM; left = STABLE_N;
        end else begin
          left--;
          if (left == 0) begin
            retries++;
            if (retries == RETRY_N) phase = M_DEAD;
            else begin phase = M_HOLD; left = RST_N; end
          end
        end
      end
      M_CONFIRM: begin
        if (!lkSeen) begin
          phase = M_SEEK; left = TIMEOUT_N;
        end else begin
          left--;
          if (left == 0) begin phase = M_LIVE; retries = 0; lowRun = 0; end
        end
      end
      M_LIVE: begin
        if (lkSeen) lowRun = 0;
        else begin
          lowRun++;
          if (lowRun == DROP_N) begin
            losses = (losses < 255) ? losses + 1 : 255;
            phase = M_HOLD; left = RST_N;
          end
        end
      end
      default: ;
    endcase
  endtask

  always @(posedge refclk) modelStep();

  always @(negedge refclk) begin
    if (modelValid) begin
      checkOutput("model_pll_rst",   pll_rst,   (phase == M_HOLD || phase == M_DEAD));
      checkOutput("model_sys_reset", sys_reset, (phase != M_LIVE));
      checkOutput("model_ready",     ready,     (phase == M_LIVE));
      checkOutput("model_fail",      fail,      (phase == M_DEAD));
      checkOutput("model_retry_cnt", retry_cnt, retries);
      checkOutput("model_loss_cnt",  loss_cnt,  losses);
    end
  end

  // One cycle: inputs change just after the rising edge, outputs read at the falling edge.
  task automatic applyStimulus(input logic r, input logic rl, input logic l);
    @(posedge refclk);
    #1;
    rst = r; relock_req = rl; pll_locked = l;
    @(negedge refclk);
  endtask

  task automatic waitReady(input int maxCycles, input string tag);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < maxCycles) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      n++;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s: ready=%0d after %0d cycles, required 1", tag, ready, n);
    end
  endtask

  initial begin
    int rstHigh, firstReady, firstFail, failCycles, sysOffset, readyLow;
    logic level, r, rl;
    int segLeft;

    applyStimulus(1'b1, 1'b0, 1'b0);

    // Clean bring-up, lock from cycle 6.
    rstHigh = 0; firstReady = 0;
    for (int k = 1; k <= 40; k++) begin
      applyStimulus(1'b0, 1'b0, k >= 6);
      if (k == 1) begin
        checkOutput("reset_pll_rst", pll_rst, 1);
        checkOutput("reset_sys_reset", sys_reset, 1);
        checkOutput("reset_ready", ready, 0);
        checkOutput("reset_fail", fail, 0);
        checkOutput("reset_loss_cnt", loss_cnt, 0);
      end
      if (pll_rst) rstHigh++;
      if (ready && firstReady == 0) firstReady = k;
    end
    checkOutput("bringup_pll_rst_cycles", rstHigh, 4);
    checkOutput("bringup_ready_cycle", firstReady, 17);
    checkOutput("bringup_retry_cnt", retry_cnt, 0);
    checkOutput("bringup_sys_reset", sys_reset, 0);

    // No lock at all: two timeouts then FAIL.
    applyStimulus(1'b1, 1'b0, 1'b0);
    rstHigh = 0; firstFail = 0; failCycles = 0;
    for (int k = 1; k <= 150; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (k <= 48 && pll_rst) rstHigh++;
      if (fail && firstFail == 0) firstFail = k;
      if (fail) failCycles++;
    end
    checkOutput("timeout_pll_rst_cycles", rstHigh, 8);
    checkOutput("timeout_fail_cycle", firstFail, 49);
    checkOutput("timeout_fail_cycles", failCycles, 102);
    checkOutput("timeout_retry_cnt", retry_cnt, 2);
    checkOutput("timeout_pll_rst", pll_rst, 1);

    // Relock out of FAIL.
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("relock_retry_cnt", retry_cnt, 0);
    checkOutput("relock_fail", fail, 0);
    checkOutput("relock_pll_rst", pll_rst, 1);
    waitReady(60, "relock_bringup");

    // Unstable lock: a single low cycle restarts the stability window.
    applyStimulus(1'b1, 1'b0, 1'b0);
    firstReady = 0;
    for (int k = 1; k <= 40; k++) begin
      applyStimulus(1'b0, 1'b0, (k >= 6) && (k != 11));
      if (ready && firstReady == 0) firstReady = k;
    end
    checkOutput("unstable_ready_cycle", firstReady, 23);
    checkOutput("unstable_retry_cnt", retry_cnt, 0);

`ifdef PLL_RESET_SEQ_LOSS_FILTER_EN
    // A dropout shorter than the filter is tolerated.
    readyLow = 0;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b0, 1'b0, k >= 2);
      if (!ready) readyLow++;
    end
    checkOutput("short_drop_ready_low", readyLow, 0);
    checkOutput("short_drop_loss_cnt", loss_cnt, 0);
`else
    readyLow = 0;
`endif

    // Real lock loss in RUN.
    sysOffset = 0;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b0, 1'b0, k >= DROP_N);
      if (sys_reset && sysOffset == 0) sysOffset = k;
    end
    checkOutput("loss_sys_reset_offset", sysOffset, DROP_N + 2);
    checkOutput("loss_loss_cnt", loss_cnt, 1);
    waitReady(60, "loss_rebringup");

    // Random lock behaviour with occasional relock and reset.
    level = 1'b1; segLeft = 10;
    for (int k = 0; k < 3000; k++) begin
      if (segLeft == 0) begin
        level = ~level;
        segLeft = level ? $urandom_range(5, 60) : $urandom_range(1, 30);
      end
      segLeft--;
      rl = ($urandom_range(0, 199) == 0);
      r  = ($urandom_range(0, 599) == 0);
      applyStimulus(r, rl, level);
    end

    // Saturate the loss counter.
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitReady(60, "sat_initial");
    for (int i = 0; i < 260; i++) begin
      for (int j = 0; j < DROP_N; j++) applyStimulus(1'b0, 1'b0, 1'b0);
      for (int j = 0; j < 3; j++) applyStimulus(1'b0, 1'b0, 1'b1);
      waitReady(60, "sat_rebringup");
    end
    checkOutput("sat_loss_cnt", loss_cnt, 255);

    // rst and relock together: rst wins.
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("rst_relock_loss_cnt", loss_cnt, 0);
    checkOutput("rst_relock_pll_rst", pll_rst, 1);
    checkOutput("rst_relock_ready", ready, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
